// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the upstream feeder, the ALU issue stage and the ALU.
// The master side drives instructions in and consumes decoded entries.
interface alu_issue_stage_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_control;
   logic            illegal;

   modport master (
      output in_valid, instr, rs1_data, rs2_data, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_control, illegal
   );

   modport slave (
      input  in_valid, instr, rs1_data, rs2_data, out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_control, illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Decodes RV64I ALU/load/store/branch words into {a, b, alu_control} and issues them
// through a registered valid/ready stage backed by a one-entry skid buffer.
module alu_issue_stage #(
   parameter int XLEN = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   alu_issue_stage_if.slave bus
);
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0100;
   localparam logic [3:0] ALU_SRA  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1001;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [3:0]      ctrl;
      logic            ill;
   } entry_t;

   state_t          r_state, w_state_next;
   entry_t          r_out, r_skid, w_entry;
   logic            w_accept, w_take, w_in_ready, w_out_valid, w_legal;
   logic [3:0]      w_ctrl;
   logic [XLEN-1:0] w_b, w_imm_i, w_imm_s, w_shamt;
   logic [6:0]      w_opcode, w_f7;
   logic [2:0]      w_f3;

   // Shared R/I funct3 map; alt selects SUB/SRA on the 000/101 slots.
   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   assign w_opcode = bus.instr[6:0];
   assign w_f3     = bus.instr[14:12];
   assign w_f7     = bus.instr[31:25];
   assign w_imm_i  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
   assign w_imm_s  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
   assign w_shamt  = {{(XLEN-6){1'b0}}, bus.instr[25:20]};

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_ctrl  = ALU_ADD;
      w_b     = bus.rs2_data;
      w_legal = 1'b1;
      case (w_opcode)
         OP_R: begin
            w_ctrl  = alu_op(w_f3, bus.instr[30]);
            w_legal = (w_f7 == 7'b0000000) ||
                      ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
         end
         OP_I: begin
            if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
               w_ctrl  = alu_op(w_f3, bus.instr[30]);
               w_b     = w_shamt;
               w_legal = (bus.instr[31:26] == 6'b000000) ||
                         ((w_f3 == 3'b101) && (bus.instr[31:26] == 6'b010000));
            end else begin
               w_ctrl = alu_op(w_f3, 1'b0);
               w_b    = w_imm_i;
            end
         end
         OP_LOAD:  w_b = w_imm_i;
         OP_STORE: w_b = w_imm_s;
         OP_BRANCH: begin
            case (w_f3)
               3'b000, 3'b001: w_ctrl = ALU_SUB;
               3'b100, 3'b101: w_ctrl = ALU_SLT;
               3'b110, 3'b111: w_ctrl = ALU_SLTU;
               default:        w_legal = 1'b0;
            endcase
         end
         default: w_legal = 1'b0;
      endcase

      w_entry     = '0;
      w_entry.ill = 1'b1;
      if (w_legal) begin
         w_entry = '{a: bus.rs1_data, b: w_b, ctrl: w_ctrl, ill: 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset || flush) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_next = S_ONE;
         S_ONE: begin
            if (w_accept && !w_take)      w_state_next = S_TWO;
            else if (!w_accept && w_take) w_state_next = S_EMPTY;
         end
         S_TWO:   if (w_take) w_state_next = S_ONE;
         default: w_state_next = S_EMPTY;
      endcase
   end

   always_comb begin
      w_in_ready  = (r_state != S_TWO);
      w_out_valid = (r_state != S_EMPTY);
   end

   assign w_accept = bus.in_valid & w_in_ready;
   assign w_take   = w_out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= '0;
      end else if (!flush) begin
         if (((r_state == S_EMPTY) && w_accept) || ((r_state == S_ONE) && w_accept && w_take)) begin
            r_out <= w_entry;
         end else if ((r_state == S_TWO) && w_take) begin
            r_out <= r_skid;
         end
      end
   end

   // NOTE: the skid entry is never observed while empty, so it carries no reset.
   always_ff @(posedge clk) begin
      if ((r_state == S_ONE) && w_accept && !w_take) begin
         r_skid <= w_entry;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.alu_a       = r_out.a;
   assign bus.alu_b       = r_out.b;
   assign bus.alu_control = r_out.ctrl;
   assign bus.illegal     = r_out.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a FIFO-of-decoded-entries model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_issue_stage;
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  ctrl;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   total = 0;
   int   bad   = 0;
   logic chk_en = 1'b0;
   exp_t q[$];
   logic m_acc, m_tk;
   logic [31:0] tbl [14];

   alu_issue_stage_if #(.XLEN(64)) bus ();

   alu_issue_stage #(.XLEN(64)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] base_op(input logic [2:0] f3);
      case (f3)
         3'd0: return 4'd2;
         3'd1: return 4'd3;
         3'd2: return 4'd8;
         3'd3: return 4'd7;
         3'd4: return 4'd9;
         3'd5: return 4'd4;
         3'd6: return 4'd1;
         default: return 4'd0;
      endcase
   endfunction

   // What the ALU must receive for one instruction, straight from the ISA rules.
   function automatic exp_t exp_of(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
      exp_t e;
      logic ok;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] hi7;
      logic [5:0] hi6;
      op = ins[6:0]; f3 = ins[14:12]; hi7 = ins[31:25]; hi6 = ins[31:26];
      ok = 1'b0; e.a = r1; e.b = r2; e.ctrl = 4'd0; e.ill = 1'b0;
      if (op == 7'h33) begin
         if (hi7 == 7'h00) begin ok = 1'b1; e.ctrl = base_op(f3); end
         else if (hi7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; e.ctrl = 4'd6; end
         else if (hi7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; e.ctrl = 4'd5; end
      end else if (op == 7'h13) begin
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.b = 64'(ins[25:20]);
            if (hi6 == 6'h00) begin ok = 1'b1; e.ctrl = base_op(f3); end
            else if (f3 == 3'd5 && hi6 == 6'h10) begin ok = 1'b1; e.ctrl = 4'd5; end
         end else begin
            ok = 1'b1; e.ctrl = base_op(f3); e.b = 64'($signed(ins[31:20]));
         end
      end else if (op == 7'h03) begin
         ok = 1'b1; e.ctrl = 4'd2; e.b = 64'($signed(ins[31:20]));
      end else if (op == 7'h23) begin
         ok = 1'b1; e.ctrl = 4'd2; e.b = 64'($signed({ins[31:25], ins[11:7]}));
      end else if (op == 7'h63) begin
         if (f3 <= 3'd1) begin ok = 1'b1; e.ctrl = 4'd6; end
         else if (f3 == 3'd4 || f3 == 3'd5) begin ok = 1'b1; e.ctrl = 4'd8; end
         else if (f3 >= 3'd6) begin ok = 1'b1; e.ctrl = 4'd7; end
      end
      if (!ok) begin e.a = '0; e.b = '0; e.ctrl = 4'd0; e.ill = 1'b1; end
      return e;
   endfunction

   // Model: at most two entries in flight, strict FIFO, cleared by reset or flush.
   always @(posedge clk) begin
      if (reset || flush) begin
         q.delete();
      end else begin
         m_acc = bus.in_valid && (q.size() < 2);
         m_tk  = (q.size() > 0) && bus.out_ready;
         if (m_tk) void'(q.pop_front());
         if (m_acc) q.push_back(exp_of(bus.instr, bus.rs1_data, bus.rs2_data));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
         check("cmp_in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
         if (q.size() > 0) begin
            check("cmp_alu_a", bus.alu_a, q[0].a);
            check("cmp_alu_b", bus.alu_b, q[0].b);
            check("cmp_alu_control", 64'(bus.alu_control), 64'(q[0].ctrl));
            check("cmp_illegal", 64'(bus.illegal), 64'(q[0].ill));
         end
      end
   end

   task automatic send_one(input string nm, input logic [31:0] ins, input logic [63:0] r1,
                           input logic [63:0] r2, input logic [3:0] ectrl, input logic [63:0] ea,
                           input logic [63:0] eb, input logic eill);
      bus.instr = ins; bus.rs1_data = r1; bus.rs2_data = r2;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({nm, "_ctrl"}, 64'(bus.alu_control), 64'(ectrl));
      check({nm, "_a"}, bus.alu_a, ea);
      check({nm, "_b"}, bus.alu_b, eb);
      check({nm, "_illegal"}, 64'(bus.illegal), 64'(eill));
      @(posedge clk); #1;
   endtask

   task automatic fill_two();
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.instr = 32'h003100B3; bus.rs1_data = 64'd11; bus.rs2_data = 64'd1;
      @(posedge clk); #1;
      bus.rs1_data = 64'd12;
      @(posedge clk); #1;
      bus.rs1_data = 64'd13;
      @(negedge clk);
      check("two_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      exp_t pin;
      logic got;
      tbl = '{32'h003100B3, 32'h403100B3, 32'h43F0D093, 32'hFFF10093, 32'hFE312E23,
              32'h00316063, 32'h00315063, 32'h0000007F, 32'h403110B3, 32'h00813083,
              32'h00511093, 32'h003140B3, 32'h003130B3, 32'h00312063};
      reset = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.instr = '0;
      bus.rs1_data = '0; bus.rs2_data = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_alu_a", bus.alu_a, 64'd0);
      check("rst_alu_b", bus.alu_b, 64'd0);
      check("rst_ctrl", 64'(bus.alu_control), 64'd0);
      check("rst_illegal", 64'(bus.illegal), 64'd0);

      pin = exp_of(32'h43F0D093, 64'd1, 64'd2);
      check("pin_srai", {52'd0, pin.ctrl, pin.b[7:0]}, {52'd0, 4'b0101, 8'd63});
      pin = exp_of(32'hFE312E23, 64'd0, 64'd0);
      check("pin_sw_b", pin.b, 64'hFFFF_FFFF_FFFF_FFFC);
      pin = exp_of(32'h00312063, 64'd4, 64'd5);
      check("pin_br_ill", {60'd0, pin.ctrl}, 64'd0);

      @(posedge clk); #1;
      send_one("add", 32'h003100B3, 64'd5, 64'd7, 4'b0010, 64'd5, 64'd7, 1'b0);
      send_one("srai", 32'h43F0D093, 64'h8000_0000_0000_0000, 64'd9, 4'b0101,
               64'h8000_0000_0000_0000, 64'd63, 1'b0);
      send_one("sub", 32'h403100B3, 64'd3, 64'd5, 4'b0110, 64'd3, 64'd5, 1'b0);
      send_one("addi", 32'hFFF10093, 64'h10, 64'd0, 4'b0010, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send_one("sw", 32'hFE312E23, 64'h100, 64'd8, 4'b0010, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      send_one("bltu", 32'h00316063, 64'd1, 64'd2, 4'b0111, 64'd1, 64'd2, 1'b0);
      send_one("bge", 32'h00315063, 64'd1, 64'd2, 4'b1000, 64'd1, 64'd2, 1'b0);
      send_one("op7f", 32'h0000007F, 64'h1234, 64'h5678, 4'b0000, 64'd0, 64'd0, 1'b1);
      send_one("sll_alt", 32'h403110B3, 64'h1234, 64'h5678, 4'b0000, 64'd0, 64'd0, 1'b1);

      // Backpressure: three words offered while the ALU stalls, then released.
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = 32'h003100B3; bus.rs2_data = 64'd0;
      bus.rs1_data = 64'd1; @(posedge clk); #1;
      bus.rs1_data = 64'd2; @(posedge clk); #1;
      bus.rs1_data = 64'd3; @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_head", bus.alu_a, 64'd1);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         if (bus.in_ready) begin got = 1'b1; break; end
      end
      #1 bus.in_valid = 1'b0;
      check("stall_i2_accepted", 64'(got), 64'd1);
      @(negedge clk);
      check("stall_i2_head", bus.alu_a, 64'd3);
      repeat (3) @(posedge clk);
      #1;

      fill_two();
      flush = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_two_valid", 64'(bus.out_valid), 64'd0);
      check("flush_two_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      fill_two();
      reset = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("reset_two_valid", 64'(bus.out_valid), 64'd0);
      check("reset_two_ready", 64'(bus.in_ready), 64'd1);
      check("reset_two_a", bus.alu_a, 64'd0);
      @(posedge clk); #1;

      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.rs1_data = 64'd21;
      @(posedge clk); #1;
      flush = 1'b1; bus.rs1_data = 64'd22;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_one_drop", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;

      for (int n = 0; n < 10000; n++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 63) == 0);
         reset = ($urandom_range(0, 199) == 0);
         bus.instr = ($urandom_range(0, 3) == 0) ? $urandom : tbl[$urandom_range(0, 13)];
         bus.rs1_data = {$urandom, $urandom};
         bus.rs2_data = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      reset = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
